// File: rtl/load_store_unit.sv
// Load/store sequencer in front of a word-addressed data memory.
// Turns byte-addressed B/H/W requests into one or two word accesses, doing
// read-modify-write for partial stores and splitting accesses that cross a
// word boundary. Out-of-range or malformed requests are answered with an error
// and never reach the memory.
module load_store_unit #(
   parameter int unsigned DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

   state_e      state_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] asm_q;

   // Access width in bytes for a funct3 size field (B=1, H=2, W=4).
   function automatic logic [2:0] size_of(input logic [1:0] sz);
      case (sz)
         2'b00:   size_of = 3'd1;
         2'b01:   size_of = 3'd2;
         default: size_of = 3'd4;
      endcase
   endfunction

   // Sign/zero extension of the little-endian assembled load value.
   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
      case (f3)
         3'b000:  extend = {{24{v[7]}}, v[7:0]};
         3'b001:  extend = {{16{v[15]}}, v[15:0]};
         3'b100:  extend = {24'h0, v[7:0]};
         3'b101:  extend = {16'h0, v[15:0]};
         default: extend = v;
      endcase
   endfunction

   // Request-side fault decode, evaluated on the incoming request in IDLE.
   logic [2:0]  req_size;
   logic [2:0]  req_end;
   logic        req_split;
   logic        req_illegal;
   logic [31:0] req_word;
   logic        req_fault;

   always_comb begin
      req_size    = size_of(req_funct3[1:0]);
      req_end     = {1'b0, req_addr[1:0]} + req_size;
      req_split   = (req_end > 3'd4);
      req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                    (req_we && req_funct3[2]);
      req_word    = {2'b00, req_addr[31:2]};
      req_fault   = req_illegal || (req_word >= DEPTH) ||
                    (req_split && ((req_word + 32'd1) >= DEPTH));
   end

   // Decode of the latched request: geometry, store lane masks and load assembly.
   logic [2:0]  size;
   logic [1:0]  offset;
   logic [2:0]  span_end;
   logic        split;
   logic [31:0] word;
   logic [3:0]  size_mask;
   logic [7:0]  byte_mask;
   logic [4:0]  sh0;
   logic [5:0]  sh1;
   logic [63:0] wdata_sh;
   logic [3:0]  lane_mask;
   logic [31:0] lane_data;
   logic [31:0] bit_mask;
   logic [31:0] asm_d;

   always_comb begin
      size      = size_of(funct3_q[1:0]);
      offset    = addr_q[1:0];
      span_end  = {1'b0, offset} + size;
      split     = (span_end > 3'd4);
      word      = {2'b00, addr_q[31:2]};
      size_mask = (size == 3'd1) ? 4'b0001 : (size == 3'd2) ? 4'b0011 : 4'b1111;
      byte_mask = {4'b0000, size_mask} << offset;
      sh0       = {offset, 3'b000};
      // Bytes taken from the second word land above the 4-o bytes of the first.
      sh1       = 6'd32 - {1'b0, sh0};
      wdata_sh  = {32'h0, wdata_q} << sh0;
      lane_mask = (state_q == StAcc1) ? byte_mask[7:4] : byte_mask[3:0];
      lane_data = (state_q == StAcc1) ? wdata_sh[63:32] : wdata_sh[31:0];
      for (int i = 0; i < 4; i++) begin
         bit_mask[8*i +: 8] = {8{lane_mask[i]}};
      end
      asm_d = (state_q == StAcc1) ? (asm_q | (mem_rd << sh1)) : (mem_rd >> sh0);
   end

   // Memory-side outputs decoded from state and the latched request.
   always_comb begin
      mem_we = 1'b0;
      mem_a  = 32'h0;
      mem_wd = 32'h0;
      if (state_q == StAcc0 || state_q == StAcc1) begin
         mem_a = (state_q == StAcc1) ? (word + 32'd1) : word;
         if (we_q) begin
            mem_we = 1'b1;
            mem_wd = (mem_rd & ~bit_mask) | (lane_data & bit_mask);
         end
      end
   end

   assign req_ready = (state_q == StIdle);

   // Sequencer FSM with registered response outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         we_q       <= 1'b0;
         funct3_q   <= 3'b000;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         asm_q      <= 32'h0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               resp_valid <= 1'b0;
               if (req_valid) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  if (req_fault) begin
                     state_q    <= StResp;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                  end else begin
                     state_q <= StAcc0;
                  end
               end
            end
            StAcc0: begin
               asm_q <= asm_d;
               if (split) begin
                  state_q <= StAcc1;
               end else begin
                  state_q    <= StResp;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= we_q ? 32'h0 : extend(funct3_q, asm_d);
               end
            end
            StAcc1: begin
               asm_q      <= asm_d;
               state_q    <= StResp;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= we_q ? 32'h0 : extend(funct3_q, asm_d);
            end
            StResp: begin
               resp_valid <= 1'b0;
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
